// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding,
// mode codes and a compile-time log2 used to size the step counter.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell reused every
// step of the serial operation.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB first, one result bit per clock through a
// registered carry; WIDTH cycles per op plus one DONE cycle.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_var1,
  input  logic [WIDTH-1:0] i_var2,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             sum;
  logic             cout;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      o_res   <= '0;
      o_carry <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Subtraction runs as A + ~B + 1: invert B and preset the carry.
        a_sh  <= i_var1;
        b_sh  <= (i_mode == MODE_ADD) ? i_var2 : ~i_var2;
        carry <= (i_mode == MODE_SUB);
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        r_sh  <= {sum, r_sh[WIDTH-1:1]};
        carry <= cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          o_res   <= {sum, r_sh[WIDTH-1:1]};
          o_carry <= cout;
        end
      end
    end
  end

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and exhaustive bench for serial_add_sub, checked every cycle
// against an arithmetic model plus hand-computed literal results.
module tb_serial_add_sub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] var1;
  logic [WIDTH-1:0] var2;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             busy;
  logic             done;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_mode  (mode),
    .i_var1  (var1),
    .i_var2  (var2),
    .o_res   (res),
    .o_carry (carry),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden: {carry,res} of A+B, or A-B with the borrow inverted.
  function automatic logic [WIDTH:0] golden(input logic m, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    if (m) begin
      t = {1'b0, a} + {1'b0, b};
    end else begin
      t = {1'b0, a} - {1'b0, b};
      t[WIDTH] = ~t[WIDTH];
    end
    return t;
  endfunction

  // Model: cycles remaining in the current op, plus the visible outputs.
  int               m_left  = 0;
  logic             m_done  = 1'b0;
  logic [WIDTH-1:0] m_res   = '0;
  logic             m_carry = 1'b0;
  logic [WIDTH:0]   m_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_res   <= '0;
      m_carry <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done  <= 1'b1;
        m_res   <= m_pend[WIDTH-1:0];
        m_carry <= m_pend[WIDTH];
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= golden(mode, var1, var2);
        m_left <= WIDTH;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), int'(m_left > 0));
      chk("done", int'(done), int'(m_done));
      chk("res", int'(res), int'(m_res));
      chk("carry", int'(carry), int'(m_carry));
    end
  end

  // Issue one op and wait for its done; returns busy-cycle count.
  task automatic run_op(input logic m, input int a, input int b, output int busy_cycles);
    bit seen;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    var1  = WIDTH'(a);
    var2  = WIDTH'(b);
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int bc;
    int nd;
    int last_done;
    int idx;
    logic [8:0] op;
    bit seen;

    rst = 1'b1; start = 1'b0; mode = 1'b1; var1 = '0; var2 = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_res", int'(res), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    run_op(1'b1, 7, 9, bc);
    chk("add_7_9_res", int'(res), 0);
    chk("add_7_9_carry", int'(carry), 1);
    chk("add_7_9_busy_cycles", bc, WIDTH);

    run_op(1'b0, 3, 5, bc);
    chk("sub_3_5_res", int'(res), 14);
    chk("sub_3_5_carry", int'(carry), 0);

    run_op(1'b0, 9, 9, bc);
    chk("sub_9_9_res", int'(res), 0);
    chk("sub_9_9_carry", int'(carry), 1);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; var1 = 4'd2; var2 = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; var1 = 4'd15; var2 = 4'd15;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ign_done_seen", int'(seen), 1);
    chk("ign_res", int'(res), 5);
    chk("ign_carry", int'(carry), 0);
    count_dones(3 * WIDTH, nd);
    chk("ign_single_done", nd, 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; var1 = 4'd6; var2 = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_res", int'(res), 0);
    chk("abort_carry", int'(carry), 0);
    chk("abort_busy", int'(busy), 0);
    count_dones(3 * WIDTH, nd);
    chk("abort_no_done", nd, 0);
    run_op(1'b1, 6, 6, bc);
    chk("post_rst_res", int'(res), 12);
    chk("post_rst_carry", int'(carry), 0);

    // Exhaustive back-to-back with start held high.
    @(negedge clk);
    idx = 0;
    op = 9'(idx);
    start = 1'b1; mode = op[8]; var1 = op[7:4]; var2 = op[3:0];
    last_done = -1;
    while (idx < 512) begin
      seen = 1'b0;
      for (int i = 0; i < 4 * WIDTH; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        chk("b2b_timeout", 0, 1);
        break;
      end
      if (last_done >= 0) chk("b2b_spacing", cyc - last_done, WIDTH + 1);
      last_done = cyc;
      idx++;
      if (idx < 512) begin
        op = 9'(idx);
        mode = op[8]; var1 = op[7:4]; var2 = op[3:0];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
